// File: rtl/ucsbece154_mem_arbiter_pkg.sv
// Shared definitions for the I/D cache refill arbiter: FSM states, grant encodings
// and block-geometry helpers.
package ucsbece154_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BURST   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_I    = 2'b01;
    localparam logic [1:0] GNT_D    = 2'b10;

    localparam int DEFAULT_BLOCK_WORDS = 4;

    // Word-index bits inside a block, and byte-offset bits of a block-aligned address.
    function automatic int block_offset(input int block_words);
        return $clog2(block_words);
    endfunction

    function automatic int addr_offset(input int block_words);
        return 2 + $clog2(block_words);
    endfunction

    localparam int BLOCK_OFFSET = block_offset(DEFAULT_BLOCK_WORDS);
    localparam int OFFSET       = addr_offset(DEFAULT_BLOCK_WORDS);

endpackage

// File: rtl/ucsbece154_mem_arbiter_if.sv
// Bundle of the two cache refill ports, the SDRAM block-read port and arbiter status.
// The slave modport is the arbiter's view; master is the view of caches plus memory.
interface ucsbece154_mem_arbiter_if #(
    parameter int WORD_SIZE = 32
);
    logic                 IReqValid;
    logic [31:0]          IReqAddress;
    logic                 IRespValid;
    logic                 IRespLast;
    logic                 DReqValid;
    logic [31:0]          DReqAddress;
    logic                 DRespValid;
    logic                 DRespLast;
    logic [WORD_SIZE-1:0] RespData;
    logic [31:0]          MemReadAddress;
    logic                 MemReadRequest;
    logic [WORD_SIZE-1:0] MemDataIn;
    logic                 MemDataReady;
    logic [1:0]           Grant;
    logic                 Overrun;

    modport slave (
        input  IReqValid, IReqAddress, DReqValid, DReqAddress, MemDataIn, MemDataReady,
        output IRespValid, IRespLast, DRespValid, DRespLast, RespData,
               MemReadAddress, MemReadRequest, Grant, Overrun
    );

    modport master (
        output IReqValid, IReqAddress, DReqValid, DReqAddress, MemDataIn, MemDataReady,
        input  IRespValid, IRespLast, DRespValid, DRespLast, RespData,
               MemReadAddress, MemReadRequest, Grant, Overrun
    );

endinterface

// File: rtl/ucsbece154_rr_pick2.sv
// Two-way round-robin chooser: a lone requester always wins, a tie goes to the
// side named by prefer_d.
module ucsbece154_rr_pick2
    import ucsbece154_mem_arbiter_pkg::*;
(
    input  logic       i_valid,
    input  logic       d_valid,
    input  logic       prefer_d,
    output logic [1:0] choice
);

    always_comb begin
        choice = GNT_NONE;
        if (i_valid && d_valid) begin
            choice = prefer_d ? GNT_D : GNT_I;
        end else if (i_valid) begin
            choice = GNT_I;
        end else if (d_valid) begin
            choice = GNT_D;
        end
    end

endmodule

// File: rtl/ucsbece154_mem_arbiter.sv
// Shares the SDRAM block-read port between icache and dcache refills, one burst per
// grant, routing each returned word back to its owner as a registered pulse.
module ucsbece154_mem_arbiter
    import ucsbece154_mem_arbiter_pkg::*;
#(
    parameter int BLOCK_WORDS = DEFAULT_BLOCK_WORDS,
    parameter int WORD_SIZE   = 32
) (
    input  logic                    Clk,
    input  logic                    Reset,
    ucsbece154_mem_arbiter_if.slave bus
);

    localparam int               CNT_W       = block_offset(BLOCK_WORDS);
    localparam int               ADDR_OFFSET = addr_offset(BLOCK_WORDS);
    localparam logic [31:0]      ALIGN_MASK  = ~((32'd1 << ADDR_OFFSET) - 32'd1);
    localparam logic [CNT_W-1:0] LAST_WORD   = CNT_W'(BLOCK_WORDS - 1);

    state_t               state;
    logic [1:0]           grant;
    logic [1:0]           pick;
    logic [CNT_W-1:0]     word_cnt;
    logic                 prefer_d;
    logic                 mem_req;
    logic [31:0]          mem_addr;
    logic [31:0]          chosen_addr;
    logic [WORD_SIZE-1:0] resp_data;
    logic                 i_valid;
    logic                 i_last;
    logic                 d_valid;
    logic                 d_last;
    logic                 overrun;

    ucsbece154_rr_pick2 picker (
        .i_valid  (bus.IReqValid),
        .d_valid  (bus.DReqValid),
        .prefer_d (prefer_d),
        .choice   (pick)
    );

    assign chosen_addr = (pick == GNT_D) ? bus.DReqAddress : bus.IReqAddress;

    // RELEASE always costs one cycle so the controller sees MemReadRequest low between bursts.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            grant     <= GNT_NONE;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            word_cnt  <= '0;
            prefer_d  <= 1'b0;
            resp_data <= '0;
            i_valid   <= 1'b0;
            i_last    <= 1'b0;
            d_valid   <= 1'b0;
            d_last    <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            i_valid <= 1'b0;
            i_last  <= 1'b0;
            d_valid <= 1'b0;
            d_last  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.MemDataReady) begin
                        overrun <= 1'b1;
                    end
                    if (pick != GNT_NONE) begin
                        mem_addr <= chosen_addr & ALIGN_MASK;
                        mem_req  <= 1'b1;
                        grant    <= pick;
                        word_cnt <= '0;
                        prefer_d <= (pick == GNT_I);
                        state    <= BURST;
                    end
                end
                BURST: begin
                    if (bus.MemDataReady) begin
                        resp_data <= bus.MemDataIn;
                        if (grant == GNT_D) begin
                            d_valid <= 1'b1;
                        end else begin
                            i_valid <= 1'b1;
                        end
                        if (word_cnt == LAST_WORD) begin
                            if (grant == GNT_D) begin
                                d_last <= 1'b1;
                            end else begin
                                i_last <= 1'b1;
                            end
                            mem_req  <= 1'b0;
                            word_cnt <= '0;
                            state    <= RELEASE;
                        end else begin
                            word_cnt <= word_cnt + CNT_W'(1);
                        end
                    end
                end
                RELEASE: begin
                    if (bus.MemDataReady) begin
                        overrun <= 1'b1;
                    end
                    grant <= GNT_NONE;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.IRespValid     = i_valid;
    assign bus.IRespLast      = i_last;
    assign bus.DRespValid     = d_valid;
    assign bus.DRespLast      = d_last;
    assign bus.RespData       = resp_data;
    assign bus.MemReadAddress = mem_addr;
    assign bus.MemReadRequest = mem_req;
    assign bus.Grant          = grant;
    assign bus.Overrun        = overrun;

endmodule

// File: tb/tb_ucsbece154_mem_arbiter.sv
// Self-checking bench for the refill arbiter: table-driven arbitration rounds plus
// hand-written corner sequences, with a response scoreboard checked at the falling edge.
module tb_ucsbece154_mem_arbiter;
    import ucsbece154_mem_arbiter_pkg::*;

    logic Clk;
    logic Reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    ucsbece154_mem_arbiter_if #(.WORD_SIZE(32)) bus ();

    ucsbece154_mem_arbiter #(
        .BLOCK_WORDS (4),
        .WORD_SIZE   (32)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic        is_d;
        logic        last;
        logic [31:0] data;
        logic [31:0] cyc;
    } resp_t;

    typedef struct {
        logic        i_req;
        logic        d_req;
        logic [31:0] i_addr;
        logic [31:0] d_addr;
        logic [1:0]  exp_grant;
        logic [31:0] exp_addr;
    } arb_vec_t;

    resp_t    exp_q[$];
    arb_vec_t vecs[8];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Every response pulse must match the oldest outstanding expected word, in the expected cycle.
    always @(negedge Clk) begin
        resp_t e;
        logic [3:0] exp_flags;
        if (bus.IRespValid || bus.DRespValid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("[TB] FAIL unexpected_resp: got I=%0b D=%0b data 0x%08h, expected no response (cycle %0d)",
                         bus.IRespValid, bus.DRespValid, bus.RespData, cyc);
            end else begin
                e = exp_q.pop_front();
                exp_flags = e.is_d ? {1'b1, e.last, 2'b00} : {2'b00, 1'b1, e.last};
                checkOutput("resp_flags", 32'({bus.DRespValid, bus.DRespLast, bus.IRespValid, bus.IRespLast}),
                            32'(exp_flags));
                checkOutput("resp_data", bus.RespData, e.data);
                checkOutput("resp_cycle", 32'(cyc), e.cyc);
            end
        end else if (bus.IRespLast || bus.DRespLast) begin
            n_checks++;
            $display("[TB] FAIL stray_last: got I=%0b D=%0b, expected 0 without valid", bus.IRespLast, bus.DRespLast);
        end
    end

    task automatic applyStimulus(input logic i_req, input logic d_req, input logic [31:0] i_addr,
                                 input logic [31:0] d_addr);
        bus.IReqValid   = i_req;
        bus.DReqValid   = d_req;
        bus.IReqAddress = i_addr;
        bus.DReqAddress = d_addr;
        @(posedge Clk);
        #1;
    endtask

    // Drives the memory side for plen cycles; each ready cycle queues the word the owner should see next cycle.
    task automatic driveBurst(input logic own_d, input logic [31:0] exp_addr, input logic [31:0] base,
                              input logic [15:0] pattern, input int plen, input int first_word);
        int    words;
        resp_t e;
        words = first_word;
        for (int k = 0; k < plen; k++) begin
            checkOutput("burst_req", 32'(bus.MemReadRequest), 32'd1);
            checkOutput("burst_addr", bus.MemReadAddress, exp_addr);
            checkOutput("burst_grant", 32'(bus.Grant), own_d ? 32'(GNT_D) : 32'(GNT_I));
            bus.MemDataReady = pattern[k];
            bus.MemDataIn    = base + 32'(words);
            if (pattern[k]) begin
                e.is_d = own_d;
                e.last = (words == 3);
                e.data = base + 32'(words);
                e.cyc  = 32'(cyc + 1);
                exp_q.push_back(e);
                words++;
            end
            @(posedge Clk);
            #1;
        end
        bus.MemDataReady = 1'b0;
    endtask

    task automatic finishRelease(input logic own_d);
        checkOutput("release_req", 32'(bus.MemReadRequest), 32'd0);
        checkOutput("release_grant", 32'(bus.Grant), own_d ? 32'(GNT_D) : 32'(GNT_I));
        @(posedge Clk);
        #1;
        checkOutput("idle_grant", 32'(bus.Grant), 32'(GNT_NONE));
        checkOutput("idle_req", 32'(bus.MemReadRequest), 32'd0);
    endtask

    task automatic doReset();
        Reset = 1'b1;
        bus.IReqValid    = 1'b0;
        bus.DReqValid    = 1'b0;
        bus.MemDataReady = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at time %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b1, 32'h0000_1004, 32'h0000_2008, GNT_I, 32'h0000_1000};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_1004, 32'h0000_2008, GNT_D, 32'h0000_2000};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_101C, 32'h0000_2030, GNT_I, 32'h0000_1010};
        vecs[3] = '{1'b1, 1'b1, 32'h0000_101C, 32'h0000_2030, GNT_D, 32'h0000_2030};
        vecs[4] = '{1'b0, 1'b1, 32'h0000_101C, 32'h0000_20FF, GNT_D, 32'h0000_20F0};
        vecs[5] = '{1'b1, 1'b1, 32'h0000_3003, 32'h0000_20FF, GNT_I, 32'h0000_3000};
        vecs[6] = '{1'b1, 1'b0, 32'h0000_300C, 32'h0000_20FF, GNT_I, 32'h0000_3000};
        vecs[7] = '{1'b1, 1'b1, 32'h0000_4444, 32'h0000_5555, GNT_D, 32'h0000_5550};

        bus.IReqValid    = 1'b0;
        bus.DReqValid    = 1'b0;
        bus.IReqAddress  = '0;
        bus.DReqAddress  = '0;
        bus.MemDataIn    = '0;
        bus.MemDataReady = 1'b0;
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        checkOutput("reset_grant", 32'(bus.Grant), 32'(GNT_NONE));
        checkOutput("reset_req", 32'(bus.MemReadRequest), 32'd0);
        checkOutput("reset_addr", bus.MemReadAddress, 32'd0);
        checkOutput("reset_data", bus.RespData, 32'd0);
        checkOutput("reset_overrun", 32'(bus.Overrun), 32'd0);
        doReset();

        $display("[TB] single icache burst");
        applyStimulus(1'b1, 1'b0, 32'h0000_1234, 32'h0);
        driveBurst(1'b0, 32'h0000_1230, 32'hA0A0_0000, 16'h000F, 4, 0);
        bus.IReqValid = 1'b0;
        finishRelease(1'b0);

        $display("[TB] round-robin table");
        doReset();
        for (int r = 0; r < 8; r++) begin
            applyStimulus(vecs[r].i_req, vecs[r].d_req, vecs[r].i_addr, vecs[r].d_addr);
            checkOutput("rr_grant", 32'(bus.Grant), 32'(vecs[r].exp_grant));
            checkOutput("rr_addr", bus.MemReadAddress, vecs[r].exp_addr);
            driveBurst(vecs[r].exp_grant == GNT_D, vecs[r].exp_addr, 32'hB000_0000 + 32'(r << 8),
                       16'h000F, 4, 0);
            finishRelease(vecs[r].exp_grant == GNT_D);
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("rr_idle_grant", 32'(bus.Grant), 32'(GNT_NONE));

        $display("[TB] dcache burst with ready gaps");
        applyStimulus(1'b0, 1'b1, 32'h0, 32'h0000_8888);
        driveBurst(1'b1, 32'h0000_8880, 32'hC0C0_0000, 16'h0059, 7, 0);
        bus.DReqValid = 1'b0;
        finishRelease(1'b1);

        $display("[TB] address change and valid drop mid-burst");
        applyStimulus(1'b1, 1'b0, 32'h2000_0008, 32'h0);
        driveBurst(1'b0, 32'h2000_0000, 32'hD0D0_0000, 16'h0001, 1, 0);
        bus.IReqAddress = 32'hFFFF_FFF0;
        bus.IReqValid   = 1'b0;
        driveBurst(1'b0, 32'h2000_0000, 32'hD0D0_0000, 16'h0007, 3, 1);
        finishRelease(1'b0);

        $display("[TB] reset in the middle of a burst");
        applyStimulus(1'b1, 1'b0, 32'h0000_0100, 32'h0);
        driveBurst(1'b0, 32'h0000_0100, 32'hE0E0_0000, 16'h0003, 2, 0);
        bus.IReqValid = 1'b0;
        @(negedge Clk);
        #2;
        Reset = 1'b1;
        #1;
        checkOutput("async_grant", 32'(bus.Grant), 32'(GNT_NONE));
        checkOutput("async_req", 32'(bus.MemReadRequest), 32'd0);
        checkOutput("async_addr", bus.MemReadAddress, 32'd0);
        checkOutput("async_data", bus.RespData, 32'd0);
        checkOutput("async_ivalid", 32'(bus.IRespValid), 32'd0);
        checkOutput("queue_at_reset", 32'(exp_q.size()), 32'd0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'h0000_0040, 32'h0);
        checkOutput("post_reset_grant", 32'(bus.Grant), 32'(GNT_I));
        driveBurst(1'b0, 32'h0000_0040, 32'hF0F0_0000, 16'h000F, 4, 0);
        bus.IReqValid = 1'b0;
        finishRelease(1'b0);

        $display("[TB] overrun flag");
        checkOutput("overrun_clear", 32'(bus.Overrun), 32'd0);
        bus.MemDataReady = 1'b1;
        bus.MemDataIn    = 32'hDEAD_BEEF;
        @(posedge Clk);
        #1;
        bus.MemDataReady = 1'b0;
        checkOutput("overrun_set", 32'(bus.Overrun), 32'd1);
        applyStimulus(1'b0, 1'b1, 32'h0, 32'h0000_0700);
        driveBurst(1'b1, 32'h0000_0700, 32'h1234_0000, 16'h000F, 4, 0);
        bus.DReqValid = 1'b0;
        finishRelease(1'b1);
        checkOutput("overrun_sticky", 32'(bus.Overrun), 32'd1);
        doReset();
        checkOutput("overrun_reset", 32'(bus.Overrun), 32'd0);

        @(posedge Clk);
        #1;
        checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
